// File: rtl/alu8_reg16.sv
// 8-bit ALU with a registered 16-bit result, loaded when en=1; rst clears it.
// Optional build macro ALU_SHIFT_BY_B_EN: opcode 7 shifts by b[2:0], left when b[3]=1.
module alu8_reg16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [3:0]  com,
    input  logic        en,
    output logic [15:0] y
);

    localparam logic [3:0] OP_MOD  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_INC  = 4'h5;
    localparam logic [3:0] OP_DEC  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_XOR  = 4'hB;
    localparam logic [3:0] OP_XNOR = 4'hC;
    localparam logic [3:0] OP_NAND = 4'hD;
    localparam logic [3:0] OP_NOR  = 4'hE;
    localparam logic [3:0] OP_NEG  = 4'hF;

    logic [15:0] a_ext;
    logic [15:0] b_ext;
    logic [7:0]  b_safe;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic [15:0] alu_r;
    logic [15:0] shift_r;
    logic [15:0] y_d;
    logic [15:0] y_q;

    assign a_ext = {8'h00, a};
    assign b_ext = {8'h00, b};

    // A zero divisor is replaced by 1 so the divider never yields X;
    // the b=0 cases are then overridden with their fixed results below.
    assign b_safe = (b == 8'd0) ? 8'd1 : b;
    assign quot   = a / b_safe;
    assign rem    = a % b_safe;

`ifdef ALU_SHIFT_BY_B_EN
    assign shift_r = b[3] ? (a_ext << b[2:0]) : {8'h00, a >> b[2:0]};
`else
    assign shift_r = {8'h00, 1'b0, a[7:1]};
`endif

    always_comb begin
        alu_r = 16'h0000;
        case (com)
            OP_MOD:  alu_r = (b == 8'd0) ? a_ext : {8'h00, rem};
            OP_ADD:  alu_r = a_ext + b_ext;
            OP_SUB:  alu_r = a_ext - b_ext;
            OP_MUL:  alu_r = a_ext * b_ext;
            OP_DIV:  alu_r = (b == 8'd0) ? 16'hFFFF : {8'h00, quot};
            OP_INC:  alu_r = a_ext + 16'd1;
            OP_DEC:  alu_r = a_ext - 16'd1;
            OP_SHR:  alu_r = shift_r;
            OP_AND:  alu_r = {8'h00, a & b};
            OP_OR:   alu_r = {8'h00, a | b};
            OP_NOT:  alu_r = {8'h00, ~a};
            OP_XOR:  alu_r = {8'h00, a ^ b};
            OP_XNOR: alu_r = {8'h00, ~(a ^ b)};
            OP_NAND: alu_r = {8'h00, ~(a & b)};
            OP_NOR:  alu_r = {8'h00, ~(a | b)};
            OP_NEG:  alu_r = 16'h0000 - a_ext;
            default: alu_r = 16'h0000;
        endcase
    end

    assign y_d = en ? alu_r : y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 16'h0000;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_alu8_reg16.sv
// Bench for alu8_reg16: directed plan values plus exhaustive and random sweeps
// checked against an integer-arithmetic reference model.
module tb_alu8_reg16;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  com;
    logic        en;
    logic [15:0] y;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_y;
    logic [15:0] exp_q[$];

    alu8_reg16 dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .com(com),
        .en(en),
        .y(y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input int ia, input int ib, input int op);
        int r;
        case (op)
            0:  r = (ib == 0) ? ia : ia % ib;
            1:  r = ia + ib;
            2:  r = ia - ib;
            3:  r = ia * ib;
            4:  r = (ib == 0) ? 65535 : ia / ib;
`ifdef ALU_SHIFT_BY_B_EN
            7:  r = ((ib & 8) != 0) ? (ia << (ib & 7)) : (ia >> (ib & 7));
`else
            7:  r = ia / 2;
`endif
            5:  r = ia + 1;
            6:  r = ia - 1;
            8:  r = ia & ib;
            9:  r = ia | ib;
            10: r = 255 - ia;
            11: r = ia ^ ib;
            12: r = 255 - (ia ^ ib);
            13: r = 255 - (ia & ib);
            14: r = 255 - (ia | ib);
            15: r = -ia;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] e);
        n_checks++;
        assert (y === e) else begin
            n_fail++;
            $error("FAIL %s: y=%h expected %h", tag, y, e);
        end
    endtask

    // Drive one cycle of inputs, predict y, clock it, then compare.
    task automatic step(input logic [7:0] sa, input logic [7:0] sb, input logic [3:0] sc,
                        input logic se, input logic sr, input string tag);
        a   = sa;
        b   = sb;
        com = sc;
        en  = se;
        rst = sr;
        if (sr)      exp_y = 16'h0000;
        else if (se) exp_y = model(int'(sa), int'(sb), int'(sc));
        exp_q.push_back(exp_y);
        @(posedge clk);
        #1;
        check(tag, exp_q.pop_front());
    endtask

    initial begin
        a = 8'h00; b = 8'h00; com = 4'h0; en = 1'b0; rst = 1'b1;
        exp_y = 16'h0000;

        // Reset behaviour
        step(8'd0, 8'd0, 4'h0, 1'b0, 1'b1, "init_reset");
        step(8'd233, 8'd20, 4'h3, 1'b1, 1'b0, "load_1234");
        check("load_1234_const", 16'h1234);
        step(8'd233, 8'd20, 4'h3, 1'b1, 1'b1, "reset_clears");
        check("reset_clears_const", 16'h0000);
        step(8'd7, 8'd9, 4'h1, 1'b1, 1'b1, "reset_over_en");
        check("reset_over_en_const", 16'h0000);

        // Arithmetic
        step(8'd5, 8'd3, 4'h1, 1'b1, 1'b0, "add_5_3");     check("add_5_3_c", 16'h0008);
        step(8'd5, 8'd3, 4'h2, 1'b1, 1'b0, "sub_5_3");     check("sub_5_3_c", 16'h0002);
        step(8'd3, 8'd5, 4'h2, 1'b1, 1'b0, "sub_3_5");     check("sub_3_5_c", 16'hFFFE);
        step(8'd255, 8'd255, 4'h3, 1'b1, 1'b0, "mul_max"); check("mul_max_c", 16'hFE01);
        step(8'd255, 8'd1, 4'h1, 1'b1, 1'b0, "add_carry"); check("add_carry_c", 16'h0100);

        // Divide / modulo
        step(8'd15, 8'd4, 4'h4, 1'b1, 1'b0, "div_15_4");   check("div_15_4_c", 16'h0003);
        step(8'd15, 8'd4, 4'h0, 1'b1, 1'b0, "mod_15_4");   check("mod_15_4_c", 16'h0003);
        step(8'd9, 8'd0, 4'h4, 1'b1, 1'b0, "div_by_0");    check("div_by_0_c", 16'hFFFF);
        step(8'd9, 8'd0, 4'h0, 1'b1, 1'b0, "mod_by_0");    check("mod_by_0_c", 16'h0009);

        // Logic sweep
        step(8'hA5, 8'h0F, 4'h8, 1'b1, 1'b0, "and");  check("and_c", 16'h0005);
        step(8'hA5, 8'h0F, 4'h9, 1'b1, 1'b0, "or");   check("or_c", 16'h00AF);
        step(8'hA5, 8'h0F, 4'hB, 1'b1, 1'b0, "xor");  check("xor_c", 16'h00AA);
        step(8'hA5, 8'h0F, 4'hC, 1'b1, 1'b0, "xnor"); check("xnor_c", 16'h0055);
        step(8'hA5, 8'h0F, 4'hD, 1'b1, 1'b0, "nand"); check("nand_c", 16'h00FA);
        step(8'hA5, 8'h0F, 4'hE, 1'b1, 1'b0, "nor");  check("nor_c", 16'h0050);
        step(8'hA5, 8'h0F, 4'hA, 1'b1, 1'b0, "not");  check("not_c", 16'h005A);
        step(8'hA5, 8'h00, 4'h7, 1'b1, 1'b0, "shr");  check("shr_c", 16'h0052);
        step(8'hA5, 8'h0F, 4'hF, 1'b1, 1'b0, "neg");  check("neg_c", 16'hFF5B);
        step(8'd0, 8'h0F, 4'hF, 1'b1, 1'b0, "neg0");  check("neg0_c", 16'h0000);
        step(8'd0, 8'h0F, 4'h5, 1'b1, 1'b0, "inc0");  check("inc0_c", 16'h0001);
        step(8'd255, 8'h0F, 4'h5, 1'b1, 1'b0, "inc255"); check("inc255_c", 16'h0100);
        step(8'd0, 8'h0F, 4'h6, 1'b1, 1'b0, "dec0");  check("dec0_c", 16'hFFFF);

        // Enable / hold
        step(8'd5, 8'd3, 4'h1, 1'b1, 1'b0, "en_load");
        for (int i = 0; i < 4; i++) begin
            step(8'd1, 8'd1, 4'h3, 1'b0, 1'b0, "en_hold");
            check("en_hold_c", 16'h0008);
        end
        step(8'd1, 8'd1, 4'h3, 1'b1, 1'b0, "en_raise"); check("en_raise_c", 16'h0001);

        // Opcode 7 with b selecting shift amount/direction
`ifdef ALU_SHIFT_BY_B_EN
        step(8'h81, 8'h0A, 4'h7, 1'b1, 1'b0, "shl_b"); check("shl_b_c", 16'h0204);
        step(8'h81, 8'h03, 4'h7, 1'b1, 1'b0, "shr_b"); check("shr_b_c", 16'h0010);
`else
        step(8'h81, 8'h0A, 4'h7, 1'b1, 1'b0, "shr_b_ign"); check("shr_b_ign_c", 16'h0040);
`endif

        // Exhaustive small-operand sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int op = 0; op < 16; op++) begin
                    step(8'(ia), 8'(ib), 4'(op), 1'b1, 1'b0, "sweep");
                end
            end
        end

        // Random full-range operands with random enable and occasional reset
        for (int i = 0; i < 600; i++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu8_reg16.md
Name: alu8_reg16

Overview:
- 8-bit combinational ALU with a registered 16-bit result, selected by a 4-bit opcode.
- Used as the datapath arithmetic/logic unit.
- Operands and opcode are sampled on the rising clock edge when enabled.
- The widened result register holds full products, carries and two's-complement negatives.

Parameters:
- None. Operand width is fixed at 8 and result width at 16.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a    input  8  operand A (unsigned unless the op says otherwise)
- b    input  8  operand B (unsigned)
- com  input  4  opcode select
- en   input  1  operation enable
- y    output 16  registered result

Behaviour:
- Reset: rst=1 at a rising edge forces y=16'h0000. rst has priority over en. Reset mid-operation discards the pending result.
- Latency: 1 cycle. The result of a/b/com sampled at edge N is visible on y after edge N.
- Hold: en=0 (and rst=0) means y holds its previous value. No operation is performed.
- Opcodes (R = value loaded into y when en=1):
  - 0 MOD: R = a % b, zero-extended. If b=0, R = {8'h00,a}.
  - 1 ADD: R = a + b, 9-bit sum zero-extended (carry in y[8]).
  - 2 SUB: R = a - b as 16-bit two's complement (e.g. 3-5 = 16'hFFFE).
  - 3 MUL: R = a * b, full 16-bit unsigned product.
  - 4 DIV: R = a / b, quotient zero-extended. If b=0, R = 16'hFFFF.
  - 5 INC: R = a + 1, 9-bit zero-extended (255 → 16'h0100).
  - 6 DEC: R = a - 1, 16-bit two's complement (0 → 16'hFFFF).
  - 7 SHR: R = {8'h00, a >> 1}, logical shift.
  - 8 AND: R = {8'h00, a & b}.
  - 9 OR: R = {8'h00, a | b}.
  - A NOT: R = {8'h00, ~a}; b ignored.
  - B XOR: R = {8'h00, a ^ b}.
  - C XNOR: R = {8'h00, ~(a ^ b)}.
  - D NAND: R = {8'h00, ~(a & b)}.
  - E NOR: R = {8'h00, ~(a | b)}.
  - F NEG: R = 16-bit two's complement of zero-extended a (5 → 16'hFFFB, 0 → 16'h0000).
- Opcode space: all 16 codes are defined, so there is no default/illegal case. There is no dedicated shift-left opcode in the base build.
- No X propagation: y must never go X after the first reset. Divide-by-zero results are fixed as above.
- Operand and opcode changes between edges have no effect on y.

Optional Feature:
- Macro: ALU_SHIFT_BY_B_EN
- Defined:
  - SHR shifts by b[2:0]: R = {8'h00, a >> b[2:0]}.
  - Opcode 7 with b[3]=1 performs a left shift instead: R = {8'h00, a} << b[2:0], 16-bit, with no bits lost.
- Undefined: SHR is a fixed shift right by 1 and b is ignored for opcode 7.

Test Plan:
- Reset: rst=1 for one edge after y was 16'h1234 → y=16'h0000 on the next cycle. Hold rst=1 with en=1 → y stays 0.
- Arithmetic: en=1, a=5, b=3, com=1 → y=16'h0008 one cycle later. com=2 → 16'h0002. a=3, b=5, com=2 → 16'hFFFE. a=255, b=255, com=3 → 16'hFE01. a=255, b=1, com=1 → 16'h0100.
- Divide/modulo: a=15, b=4 → com=4 gives 16'h0003 and com=0 gives 16'h0003. a=9, b=0 → com=4 gives 16'hFFFF and com=0 gives 16'h0009.
- Logic sweep: a=8'hA5, b=8'h0F:
  - AND → 16'h0005; OR → 16'h00AF; XOR → 16'h00AA; XNOR → 16'h0055.
  - NAND → 16'h00FA; NOR → 16'h0050; NOT → 16'h005A.
  - SHR → 16'h0052; NEG → 16'hFF5B.
  - INC with a=0 → 16'h0001; DEC with a=0 → 16'hFFFF.
- Enable: load ADD 5+3 (y=8), then drop en and apply a=1, b=1, com=3 for 4 cycles → y stays 16'h0008. Raise en → y=16'h0001 one cycle later.
- Exhaustive (base build): loop a,b over 0..15 and com over 0..15 with en=1, comparing y against a reference model one cycle after each stimulus. Under ALU_SHIFT_BY_B_EN: a=8'h81, b=4'hA, com=7 → 16'h0204.
